// File: rtl/lfu_pkg.sv
// Shared types and helpers for the LFU replacement controller.
//   lfu_state_t   : controller FSM states (idle / evaluate / update)
//   Lfu*          : default geometry (ways, counter width, number of sets)
//   onehot_lowest : keeps only the lowest set bit of a vector
package lfu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StUpdate
  } lfu_state_t;

  localparam int unsigned LfuWays    = 4;
  localparam int unsigned LfuCntW    = 4;
  localparam int unsigned LfuNumSets = 4;

  // Two's-complement trick: v & -v isolates the least significant set bit.
  function automatic logic [31:0] onehot_lowest(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/lfu_min_select.sv
// Combinational minimum finder over one set's frequency counters.
// Ports:
//   cnt_i     : WAYS packed counters, way0 in the LSBs
//   min_sel_o : one-hot way holding the smallest counter; ties go to the lowest index
module lfu_min_select #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic [WAYS-1:0][CNT_W-1:0] cnt_i,
  output logic [WAYS-1:0]            min_sel_o
);

  logic [CNT_W-1:0] min_val;
  int               min_idx;

  always_comb begin
    min_val = cnt_i[0];
    min_idx = 0;
    // Strict less-than keeps the earlier (lower) index on ties.
    for (int w = 1; w < WAYS; w++) begin
      if (cnt_i[w] < min_val) begin
        min_val = cnt_i[w];
        min_idx = w;
      end
    end
    min_sel_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      min_sel_o[w] = (w == min_idx);
    end
  end

endmodule

// File: rtl/lfu_replace_ctrl.sv
// Per-set LFU replacement controller. One access report is handled every three
// cycles: IDLE accepts, EVAL finds the least-used way, UPDATE writes counters and
// pulses the response.
// Ports:
//   clk_i, reset_i            : clock, synchronous active-high reset
//   req_valid_i / req_ready_o : access report handshake
//   req_set_i, req_hit_i      : set index and hit(1)/miss(0)
//   req_way_i                 : one-hot hit way (lowest set bit used if not one-hot)
//   flush_i                   : clear every counter (honoured only in IDLE)
//   resp_valid_o              : one-cycle pulse qualifying resp_way_sel_o
//   resp_way_sel_o            : hit way on a hit, victim way on a miss
//   dbg_set_i / dbg_counts_o  : combinational counter read, way0 in the LSBs
// Build option: define LFU_AGING_EN to halve the whole set when a hit finds its
// counter already saturated, instead of simply saturating.
module lfu_replace_ctrl
  import lfu_pkg::*;
#(
  parameter int unsigned WAYS     = LfuWays,
  parameter int unsigned CNT_W    = LfuCntW,
  parameter int unsigned NUM_SETS = LfuNumSets,
  localparam int unsigned SetW    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SetW-1:0]       req_set_i,
  input  logic                  req_hit_i,
  input  logic [WAYS-1:0]       req_way_i,
  input  logic                  flush_i,
  output logic                  resp_valid_o,
  output logic [WAYS-1:0]       resp_way_sel_o,
  input  logic [SetW-1:0]       dbg_set_i,
  output logic [WAYS*CNT_W-1:0] dbg_counts_o
);

  typedef logic [WAYS-1:0][CNT_W-1:0] row_t;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  lfu_state_t      state_q;
  row_t            cnt_q [NUM_SETS];
  logic [SetW-1:0] set_q;
  logic            hit_q;
  logic [WAYS-1:0] way_q;
  logic [WAYS-1:0] sel_q;
  logic            resp_valid_q;

  row_t            cur_row;
  row_t            upd_row;
  logic [WAYS-1:0] min_sel;

  assign cur_row = cnt_q[set_q];

  lfu_min_select #(
    .WAYS  (WAYS),
    .CNT_W (CNT_W)
  ) u_min_select (
    .cnt_i     (cur_row),
    .min_sel_o (min_sel)
  );

  // New counter row for the latched set; sel_q holds the victim during UPDATE.
  always_comb begin
    upd_row = cur_row;
    if (hit_q) begin
      for (int w = 0; w < WAYS; w++) begin
        if (way_q[w]) begin
          if (cur_row[w] != CntMax) begin
            upd_row[w] = cur_row[w] + 1'b1;
          end
`ifdef LFU_AGING_EN
          else begin
            for (int v = 0; v < WAYS; v++) begin
              upd_row[v] = cur_row[v] >> 1;
            end
            upd_row[w] = (CntMax >> 1) + 1'b1;
          end
`endif
        end
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (sel_q[w]) begin
          upd_row[w] = CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      set_q        <= '0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      sel_q        <= '0;
      resp_valid_q <= 1'b0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        cnt_q[s] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
              cnt_q[s] <= '0;
            end
          end else if (req_valid_i) begin
            set_q   <= req_set_i;
            hit_q   <= req_hit_i;
            way_q   <= WAYS'(onehot_lowest(32'(req_way_i)));
            state_q <= StEval;
          end
        end
        StEval: begin
          sel_q        <= hit_q ? way_q : min_sel;
          resp_valid_q <= 1'b1;
          state_q      <= StUpdate;
        end
        StUpdate: begin
          cnt_q[set_q] <= upd_row;
          sel_q        <= '0;
          resp_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Flush takes the IDLE cycle, so a report offered alongside it must be refused.
  assign req_ready_o    = (state_q == StIdle) && !flush_i;
  assign resp_valid_o   = resp_valid_q;
  assign resp_way_sel_o = sel_q;
  assign dbg_counts_o   = cnt_q[dbg_set_i];

endmodule

// File: tb/tb_lfu_replace_ctrl.sv
// Directed bench for lfu_replace_ctrl (WAYS=4, CNT_W=4, NUM_SETS=4).
// dbg values below are written as nibbles way3..way0, e.g. 16'h1333 = {3,3,3,1} way0..3.
module tb_lfu_replace_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_set;
  logic        req_hit;
  logic [3:0]  req_way;
  logic        flush;
  logic        resp_valid;
  logic [3:0]  resp_way_sel;
  logic [1:0]  dbg_set;
  logic [15:0] dbg_counts;

  int n_ok  = 0;
  int n_chk = 0;

  always #10 clk = ~clk;

  lfu_replace_ctrl #(
    .WAYS     (4),
    .CNT_W    (4),
    .NUM_SETS (4)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_set_i      (req_set),
    .req_hit_i      (req_hit),
    .req_way_i      (req_way),
    .flush_i        (flush),
    .resp_valid_o   (resp_valid),
    .resp_way_sel_o (resp_way_sel),
    .dbg_set_i      (dbg_set),
    .dbg_counts_o   (dbg_counts)
  );

  // A hit must name exactly one way.
  always @(posedge clk) begin
    if (!reset && req_valid && req_ready && req_hit && !$onehot(req_way)) begin
      $error("illegal non-one-hot req_way %b on hit", req_way);
    end
  end

  task automatic read_dbg(input logic [1:0] s, output logic [15:0] v);
    dbg_set = s;
    #1;
    v = dbg_counts;
  endtask

  // Issues one report from IDLE and returns the response select and the number of
  // edges from acceptance to the first cycle resp_valid is seen (-1 on timeout).
  // Returns #1 after the edge that writes the counters.
  task automatic issue(input logic [1:0] s, input logic hit, input logic [3:0] way,
                       output logic [3:0] sel, output int lat);
    req_valid = 1'b1;
    req_set   = s;
    req_hit   = hit;
    req_way   = way;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_hit   = 1'b0;
    req_way   = '0;
    lat = -1;
    sel = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        lat = k + 1;
        sel = resp_way_sel;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1; req_valid = 1'b0; req_set = '0; req_hit = 1'b0; req_way = '0;
    flush = 1'b0; dbg_set = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
    else n_ok++;
    n_chk++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid);
    else n_ok++;
    n_chk++; if (resp_way_sel !== 4'b0000)
      $display("FAIL reset_resp_sel got %b want 0000", resp_way_sel);
    else n_ok++;
    for (int s = 0; s < 4; s++) begin
      read_dbg(2'(s), v);
      n_chk++; if (v !== 16'h0000) $display("FAIL reset_counts set%0d got %h want 0000", s, v);
      else n_ok++;
    end
  endtask

  task automatic test_miss_fill();
    logic [3:0]  sel;
    logic [3:0]  exp_sel;
    logic [15:0] v;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      exp_sel = 4'b0001 << i;
      issue(2'd0, 1'b0, 4'b0000, sel, lat);
      n_chk++; if (sel !== exp_sel) $display("FAIL miss_fill%0d got %b want %b", i, sel, exp_sel);
      else n_ok++;
      if (i == 0) begin
        n_chk++; if (lat !== 2) $display("FAIL miss_latency got %0d want 2", lat);
        else n_ok++;
        read_dbg(2'd0, v);
        n_chk++; if (v !== 16'h0001) $display("FAIL miss_first_counts got %h want 0001", v);
        else n_ok++;
      end
    end
    read_dbg(2'd0, v);
    n_chk++; if (v !== 16'h1111) $display("FAIL miss_fill_counts got %h want 1111", v);
    else n_ok++;
  endtask

  task automatic test_victim();
    logic [3:0]  sel;
    logic [3:0]  oh;
    logic [15:0] v;
    int          lat;
    int          hit_bad = 0;
    // set1 -> {3,3,3,0}
    for (int w = 0; w < 3; w++) begin
      oh = 4'b0001 << w;
      repeat (3) begin
        issue(2'd1, 1'b1, oh, sel, lat);
        if (sel !== oh) hit_bad++;
      end
    end
    read_dbg(2'd1, v);
    n_chk++; if (v !== 16'h0333) $display("FAIL victim_build_set1 got %h want 0333", v);
    else n_ok++;
    issue(2'd1, 1'b0, 4'b0000, sel, lat);
    n_chk++; if (sel !== 4'b1000) $display("FAIL victim_way3 got %b want 1000", sel);
    else n_ok++;
    read_dbg(2'd1, v);
    n_chk++; if (v !== 16'h1333) $display("FAIL victim_set1_counts got %h want 1333", v);
    else n_ok++;
    // set3 -> {0,2,2,2}
    for (int w = 1; w < 4; w++) begin
      oh = 4'b0001 << w;
      repeat (2) begin
        issue(2'd3, 1'b1, oh, sel, lat);
        if (sel !== oh) hit_bad++;
      end
    end
    issue(2'd3, 1'b0, 4'b0000, sel, lat);
    n_chk++; if (sel !== 4'b0001) $display("FAIL victim_way0 got %b want 0001", sel);
    else n_ok++;
    read_dbg(2'd3, v);
    n_chk++; if (v !== 16'h2221) $display("FAIL victim_set3_counts got %h want 2221", v);
    else n_ok++;
    // set0 from {1,1,1,1} -> {7,7,7,7}
    for (int w = 0; w < 4; w++) begin
      oh = 4'b0001 << w;
      repeat (6) begin
        issue(2'd0, 1'b1, oh, sel, lat);
        if (sel !== oh) hit_bad++;
      end
    end
    read_dbg(2'd0, v);
    n_chk++; if (v !== 16'h7777) $display("FAIL victim_build_set0 got %h want 7777", v);
    else n_ok++;
    issue(2'd0, 1'b0, 4'b0000, sel, lat);
    n_chk++; if (sel !== 4'b0001) $display("FAIL victim_tie got %b want 0001", sel);
    else n_ok++;
    read_dbg(2'd0, v);
    n_chk++; if (v !== 16'h7771) $display("FAIL victim_tie_counts got %h want 7771", v);
    else n_ok++;
    n_chk++; if (hit_bad !== 0) $display("FAIL hit_resp_sel got %0d wrong want 0", hit_bad);
    else n_ok++;
  endtask

  task automatic test_saturate();
    logic [3:0]  sel;
    logic [15:0] v;
    logic [15:0] exp_v;
    int          lat;
    repeat (15) issue(2'd2, 1'b1, 4'b0100, sel, lat);
    read_dbg(2'd2, v);
    n_chk++; if (v !== 16'h0F00) $display("FAIL sat_at_max got %h want 0f00", v);
    else n_ok++;
    issue(2'd2, 1'b1, 4'b0100, sel, lat);
`ifdef LFU_AGING_EN
    exp_v = 16'h0800;
`else
    exp_v = 16'h0F00;
`endif
    read_dbg(2'd2, v);
    n_chk++; if (v !== exp_v) $display("FAIL sat_hit16 got %h want %h", v, exp_v);
    else n_ok++;
  endtask

  task automatic test_flush();
    logic [3:0]  sel;
    logic [15:0] v;
    int          lat;
    int          seen = 0;
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_set = 2'd0; req_hit = 1'b0; req_way = '0;
    #1;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", req_ready);
    else n_ok++;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    repeat (3) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    n_chk++; if (seen !== 0) $display("FAIL flush_no_resp got %0d pulses want 0", seen);
    else n_ok++;
    for (int s = 0; s < 4; s++) begin
      read_dbg(2'(s), v);
      n_chk++; if (v !== 16'h0000) $display("FAIL flush_counts set%0d got %h want 0000", s, v);
      else n_ok++;
    end
    issue(2'd2, 1'b0, 4'b0000, sel, lat);
    n_chk++; if (sel !== 4'b0001) $display("FAIL flush_next_miss got %b want 0001", sel);
    else n_ok++;
    n_chk++; if (lat !== 2) $display("FAIL flush_next_latency got %0d want 2", lat);
    else n_ok++;
  endtask

  task automatic test_reset_in_eval();
    logic [15:0] v;
    int          seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_set = 2'd1; req_hit = 1'b0; req_way = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_eval_ready got %b want 1", req_ready);
    else n_ok++;
    repeat (3) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    n_chk++; if (seen !== 0) $display("FAIL rst_eval_no_resp got %0d pulses want 0", seen);
    else n_ok++;
    for (int s = 0; s < 4; s++) begin
      read_dbg(2'(s), v);
      n_chk++; if (v !== 16'h0000) $display("FAIL rst_eval_counts set%0d got %h want 0000", s, v);
      else n_ok++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  sel;
    logic [3:0]  sels [2];
    logic [15:0] v;
    int          lat;
    int          acc = 0;
    int          nresp = 0;
    int          ridx [2];
    issue(2'd3, 1'b1, 4'b0010, sel, lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_set = 2'd0; req_hit = 1'b0; req_way = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) req_valid = 1'b0;
      if (req_valid && req_ready) acc++;
      if (resp_valid) begin
        if (nresp < 2) begin
          ridx[nresp] = i;
          sels[nresp] = resp_way_sel;
        end
        nresp++;
      end
      @(posedge clk); #1;
    end
    n_chk++; if (acc !== 2) $display("FAIL b2b_accepts got %0d want 2", acc);
    else n_ok++;
    n_chk++; if (nresp !== 2) $display("FAIL b2b_resps got %0d want 2", nresp);
    else n_ok++;
    if (nresp >= 2) begin
      n_chk++; if (ridx[1] - ridx[0] !== 3)
        $display("FAIL b2b_spacing got %0d want 3", ridx[1] - ridx[0]);
      else n_ok++;
      n_chk++; if (sels[0] !== 4'b0001) $display("FAIL b2b_sel0 got %b want 0001", sels[0]);
      else n_ok++;
      n_chk++; if (sels[1] !== 4'b0010) $display("FAIL b2b_sel1 got %b want 0010", sels[1]);
      else n_ok++;
    end
    read_dbg(2'd0, v);
    n_chk++; if (v !== 16'h0011) $display("FAIL b2b_set0 got %h want 0011", v);
    else n_ok++;
    read_dbg(2'd3, v);
    n_chk++; if (v !== 16'h0010) $display("FAIL b2b_set3 got %h want 0010", v);
    else n_ok++;
    read_dbg(2'd1, v);
    n_chk++; if (v !== 16'h0000) $display("FAIL b2b_set1 got %h want 0000", v);
    else n_ok++;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_victim();
    test_saturate();
    test_flush();
    test_reset_in_eval();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
